// File: rtl/mem_port_arbiter_if.sv
// Request/acknowledge bus used for the fetch, data and memory sides of mem_port_arbiter.
// The master drives the request fields; the slave answers with ready and rdata.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (read-only) and data requesters.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after MAX_STARVE data grants.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic               clk,
  input  logic               clr,
  mem_port_arbiter_if.slave  if_bus,
  mem_port_arbiter_if.slave  dm_bus,
  mem_port_arbiter_if.master mem_bus,
  output logic               owner
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   grant_dm;

  if (MAX_STARVE < 1) begin : g_bad_max_starve
    $error("MAX_STARVE must be at least 1");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(MAX_STARVE);

  logic [SW-1:0] starve_cnt;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v >= STARVE_LIMIT) ? v : v + SW'(1);
  endfunction

  // Data wins a collision unless fetch has already waited through MAX_STARVE data grants.
  assign grant_dm = dm_bus.req && !(if_bus.req && (starve_cnt >= STARVE_LIMIT));
`else
  assign grant_dm = dm_bus.req;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= IDLE;
      owner         <= 1'b0;
      mem_bus.req   <= 1'b0;
      mem_bus.we    <= 1'b0;
      mem_bus.addr  <= '0;
      mem_bus.wdata <= '0;
      if_bus.ready  <= 1'b0;
      dm_bus.ready  <= 1'b0;
      if_bus.rdata  <= '0;
      dm_bus.rdata  <= '0;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt    <= '0;
`endif
    end else begin
      if_bus.ready <= 1'b0;
      dm_bus.ready <= 1'b0;
      case (state)
        IDLE: begin
          if (if_bus.req || dm_bus.req) begin
            owner         <= grant_dm;
            mem_bus.req   <= 1'b1;
            mem_bus.we    <= grant_dm & dm_bus.we;
            mem_bus.addr  <= grant_dm ? dm_bus.addr : if_bus.addr;
            mem_bus.wdata <= grant_dm ? dm_bus.wdata : '0;
`ifdef ARB_STARVE_GUARD_EN
            if (!grant_dm)
              starve_cnt <= '0;
            else if (if_bus.req)
              starve_cnt <= sat_inc(starve_cnt);
`endif
            state <= ACCESS;
          end
        end
        // Fields stay frozen until the memory acknowledges.
        ACCESS: begin
          if (mem_bus.ready) begin
            mem_bus.req <= 1'b0;
            mem_bus.we  <= 1'b0;
            if (owner) begin
              dm_bus.ready <= 1'b1;
              if (!mem_bus.we)
                dm_bus.rdata <= mem_bus.rdata;
            end else begin
              if_bus.ready <= 1'b1;
              if_bus.rdata <= mem_bus.rdata;
            end
            state <= RESP;
          end
        end
        // The granted req is still high here and is deliberately not re-arbitrated.
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one shared single-port memory between the instruction-fetch requester (read-only) and the MEM-stage data requester (read/write). It sits between the pipeline's fetch and memory stages and the external memory interface, so one physical memory backs both program and data space. Each grant is a complete request/acknowledge transaction. Responses return registered to the requester that owns the grant.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_STARVE, 4, consecutive data grants while fetch waits before fetch is forced (used only with the guard macro)

- clk  in  1  clock; all state on rising edge
- clr  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  AW  fetch address
- if_ready  out  1  one-cycle pulse: fetch transaction complete
- if_rdata  out  DW  fetched word; valid with if_ready, held until next fetch completion
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ready
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_ready  out  1  one-cycle pulse: data transaction complete
- dm_rdata  out  DW  read data; updated only on read completion
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write strobe, qualified by mem_req
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  memory completes current access; mem_rdata valid this cycle
- mem_rdata  in  DW  memory read data
- owner  out  1  0 = fetch, 1 = data; valid while mem_req high

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: when no request, stay. When exactly one request, grant it. When both request, grant data; see Configuration for the exception. On a grant, register owner and the address, we and wdata fields, and go to ACCESS.
- ACCESS: drive mem_req=1 from the registered fields. On mem_ack, capture mem_rdata into the owner's rdata register (data writes leave dm_rdata unchanged) and go to RESP. Otherwise stay.
- RESP: pulse the owner's ready for one cycle and go to IDLE.
- Requests are never sampled in ACCESS or RESP. The granted requester's req stays high through RESP, and that must not be re-arbitrated.
- Fetch never drives mem_we. mem_we = owner & registered dm_we.
- mem_addr, mem_wdata and mem_we are registered. They are stable for the whole of ACCESS.
- The non-granted requester sees no ready and keeps waiting. Its request is not lost.

## Timing
- Reset (clr low, asynchronous): state IDLE; mem_req, mem_we, if_ready, dm_ready, owner = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; starve counter = 0.
- Reset mid-ACCESS drops mem_req immediately, with no response pulse. The memory side must tolerate the abandoned access.
- Minimum request-to-ready latency is 2 cycles:
  - cycle 0: req seen in IDLE
  - cycle 1: ACCESS, mem_req high, mem_ack may arrive the same cycle
  - cycle 2: RESP, ready high
- Each extra cycle of mem_ack delay adds 1 cycle.
- Back-to-back transactions to the same requester are separated by at least one IDLE cycle. Peak rate is one access per 3 cycles.
- A requester may raise a new req in the cycle after its ready pulse. That req is sampled in the following IDLE cycle.
- mem_ack outside ACCESS is ignored.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A saturating counter (width ceil(log2(MAX_STARVE+1))) increments on each data grant made while if_req is high.
  - It clears on any fetch grant.
  - In IDLE, with both requests high and counter >= MAX_STARVE, fetch is granted.
- ARB_STARVE_GUARD_EN undefined: strict data priority, and the counter logic is absent.

## Test plan
- Single fetch: if_req=1, if_addr=0x10, memory acks in ACCESS cycle 1 with 0xDEADBEEF -> if_ready pulses at cycle 2, if_rdata=0xDEADBEEF, mem_we=0 throughout.
- Data write with 3-cycle mem_ack delay: dm_we=1, dm_addr=0x40, dm_wdata=0x1234 -> mem_req held 3 cycles with stable fields, mem_we=1, dm_ready at cycle 4, dm_rdata unchanged.
- Simultaneous requests, fetch 0x20 and data read 0x80 -> data served first (owner=1), then fetch; if_ready arrives 3 cycles after dm_ready with immediate acks.
- Starvation, macro defined, MAX_STARVE=4: if_req held high, dm_req re-raised continuously -> 4 data grants, then the 5th grant goes to fetch. Macro undefined -> fetch is never granted while dm_req stays high.
- Reset mid-ACCESS: clr low during a pending data read -> mem_req drops asynchronously, no ready pulse, all outputs 0. After release, a new fetch completes normally.
- Spurious mem_ack in IDLE -> no state change, no ready pulse, rdata registers unchanged.
